// File: rtl/fw_ip1_cfg_static_sequencer_if.sv
// SW command bus between the op-code decoder and one device sequencer.
// Carries the decoded op-code levels, the command body and the read slot.
interface fw_ip1_cfg_static_sequencer_if;
   logic        fw_dev_id_enable;
   logic        fw_op_code_w_reset;
   logic        fw_op_code_w_cfg_static_0;
   logic        fw_op_code_r_cfg_static_0;
   logic        fw_op_code_r_status;
   logic        fw_op_code_w_execute;
   logic [23:0] sw_write24_0;
   logic [31:0] fw_read_data32;
   logic [31:0] fw_read_status32;

   modport master (
      output fw_dev_id_enable,
      output fw_op_code_w_reset,
      output fw_op_code_w_cfg_static_0,
      output fw_op_code_r_cfg_static_0,
      output fw_op_code_r_status,
      output fw_op_code_w_execute,
      output sw_write24_0,
      input  fw_read_data32,
      input  fw_read_status32
   );

   modport slave (
      input  fw_dev_id_enable,
      input  fw_op_code_w_reset,
      input  fw_op_code_w_cfg_static_0,
      input  fw_op_code_r_cfg_static_0,
      input  fw_op_code_r_status,
      input  fw_op_code_w_execute,
      input  sw_write24_0,
      output fw_read_data32,
      output fw_read_status32
   );
endinterface

// File: rtl/fw_ip1_cfg_static_sequencer.sv
// Static config bank sequencer: SW writes/reads words, EXECUTE scans them out.
// Optional scan readback check enabled by defining CFG_STATIC_READBACK_EN.
module fw_ip1_cfg_static_sequencer #(
   parameter int NUM_WORDS = 8,
   parameter int WORD_W    = 16,
   parameter int CLK_DIV   = 4
) (
   input  logic fw_axi_clk,
   input  logic fw_rst_n,
   fw_ip1_cfg_static_sequencer_if.slave sw,
   output logic scan_sclk,
   output logic scan_sdata,
   output logic scan_sload,
   input  logic scan_sdout
);

   localparam int TOTAL = NUM_WORDS * WORD_W;
   localparam int IW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LOAD,
      ST_DONE
   } state_e;

   // word 0 sits at the MSB end so flattening gives word-0-first order
   typedef logic [0:NUM_WORDS-1][WORD_W-1:0] bank_t;

   state_e            state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [15:0]       bit_cnt_q, bit_cnt_d;
   logic [TOTAL-1:0]  shreg_q, shreg_d;
   bank_t             bank_q, bank_d;
   logic              done_q, done_d;
   logic              err_idx_q, err_idx_d;
   logic              err_busy_q, err_busy_d;
   logic [31:0]       rd_q, rd_d;
   logic [31:0]       st_q, st_d;
   logic              sclk_q, sclk_d;
   logic              sdata_q, sdata_d;
   logic              sload_q, sload_d;
   logic [4:0]        op_prev_q, op_prev_d;

   logic [4:0]        op_now;
   logic [4:0]        op_rise;
   logic              acc_rst;
   logic              acc_wcfg;
   logic              acc_rcfg;
   logic              acc_exec;
   logic [7:0]        idx;
   logic              idx_ok;
   logic [IW-1:0]     widx;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] rd_word;
   logic              busy;
   logic              div_last;
   logic [DW-1:0]     div_nxt;
   logic [15:0]       cnt_inc;
   logic              mism_bit;

   assign op_now = {sw.fw_op_code_w_execute,
                    sw.fw_op_code_r_status,
                    sw.fw_op_code_r_cfg_static_0,
                    sw.fw_op_code_w_cfg_static_0,
                    sw.fw_op_code_w_reset};

   assign op_rise  = op_now & ~op_prev_q;
   assign acc_rst  = sw.fw_dev_id_enable & op_rise[0];
   assign acc_wcfg = sw.fw_dev_id_enable & ~op_rise[0] & op_rise[1];
   assign acc_rcfg = sw.fw_dev_id_enable & ~op_rise[0] & ~op_rise[1]
                   & op_rise[2];
   assign acc_exec = sw.fw_dev_id_enable & ~op_rise[0] & ~op_rise[1]
                   & ~op_rise[2] & op_rise[4];

`ifdef CFG_STATIC_READBACK_EN
   logic              rb_sel;
   logic [TOTAL-1:0]  snap_q, snap_d;
   logic [TOTAL-1:0]  cap_q, cap_d;
   logic              mism_q, mism_d;
   bank_t             cap_w;

   assign rb_sel   = sw.sw_write24_0[23];
   assign idx      = {1'b0, sw.sw_write24_0[22:16]};
   assign cap_w    = cap_q;
   assign mism_bit = mism_q;
`else
   logic unused_sdout;

   assign unused_sdout = scan_sdout;
   assign idx          = sw.sw_write24_0[23:16];
   assign mism_bit     = 1'b0;
`endif

   assign idx_ok   = {1'b0, idx} < 9'(NUM_WORDS);
   assign widx     = idx[IW-1:0];
   assign wdata    = sw.sw_write24_0[WORD_W-1:0];
   assign busy     = (state_q != ST_IDLE);
   assign div_last = (div_q == DW'(CLK_DIV - 1));
   assign div_nxt  = div_last ? '0 : div_q + DW'(1);
   assign cnt_inc  = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + 16'd1;

   // read word source: bank, or captured scan return when selected
   always_comb begin
      rd_word = bank_q[widx];
`ifdef CFG_STATIC_READBACK_EN
      if (rb_sel) rd_word = cap_w[widx];
`endif
   end

   // sequencer FSM, command handling and registered output values
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      bank_d     = bank_q;
      done_d     = done_q;
      err_idx_d  = err_idx_q;
      err_busy_d = err_busy_q;
      rd_d       = rd_q;
      op_prev_d  = op_now;
`ifdef CFG_STATIC_READBACK_EN
      snap_d     = snap_q;
      cap_d      = cap_q;
      mism_d     = mism_q;
`endif

      unique case (state_q)
         ST_SHIFT_LO: begin
            div_d = div_nxt;
            if (div_last) state_d = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            div_d = div_nxt;
            if (div_last) begin
               bit_cnt_d = cnt_inc;
               shreg_d   = shreg_q << 1;
`ifdef CFG_STATIC_READBACK_EN
               cap_d     = TOTAL'({cap_q, scan_sdout});
`endif
               if (cnt_inc == 16'(TOTAL)) state_d = ST_LOAD;
               else                       state_d = ST_SHIFT_LO;
            end
         end
         ST_LOAD: begin
            div_d = div_nxt;
            if (div_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
`ifdef CFG_STATIC_READBACK_EN
            mism_d  = (cap_q != snap_q);
`endif
         end
         default: ;
      endcase

      if (acc_rst) begin
         state_d    = ST_IDLE;
         div_d      = '0;
         bit_cnt_d  = '0;
         shreg_d    = '0;
         bank_d     = '0;
         done_d     = 1'b0;
         err_idx_d  = 1'b0;
         err_busy_d = 1'b0;
`ifdef CFG_STATIC_READBACK_EN
         snap_d     = '0;
         cap_d      = '0;
         mism_d     = 1'b0;
`endif
      end else begin
         if (acc_rcfg) begin
            rd_d = {8'h00, sw.sw_write24_0[23:16],
                    idx_ok ? 16'(rd_word) : 16'h0000};
            if (!idx_ok) err_idx_d = 1'b1;
         end
         if (acc_wcfg) begin
            if (busy)         err_busy_d   = 1'b1;
            else if (!idx_ok) err_idx_d    = 1'b1;
            else              bank_d[widx] = wdata;
         end
         if (acc_exec) begin
            if (busy) begin
               err_busy_d = 1'b1;
            end else begin
               state_d    = ST_SHIFT_LO;
               div_d      = '0;
               bit_cnt_d  = '0;
               shreg_d    = bank_q;
               done_d     = 1'b0;
               err_idx_d  = 1'b0;
               err_busy_d = 1'b0;
`ifdef CFG_STATIC_READBACK_EN
               snap_d     = bank_q;
               cap_d      = '0;
               mism_d     = 1'b0;
`endif
            end
         end
      end

      // scan pins follow the state being entered so they line up with it
      sclk_d  = (state_d == ST_SHIFT_HI);
      sload_d = (state_d == ST_LOAD);
      sdata_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI))
              & shreg_d[TOTAL-1];

      st_d = {busy, done_q, err_idx_q, err_busy_q, mism_bit,
              11'h000, bit_cnt_q};
   end

   // state and datapath registers
   always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         bank_q     <= '0;
         done_q     <= 1'b0;
         err_idx_q  <= 1'b0;
         err_busy_q <= 1'b0;
         rd_q       <= '0;
         st_q       <= '0;
         sclk_q     <= 1'b0;
         sdata_q    <= 1'b0;
         sload_q    <= 1'b0;
         op_prev_q  <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         bank_q     <= bank_d;
         done_q     <= done_d;
         err_idx_q  <= err_idx_d;
         err_busy_q <= err_busy_d;
         rd_q       <= rd_d;
         st_q       <= st_d;
         sclk_q     <= sclk_d;
         sdata_q    <= sdata_d;
         sload_q    <= sload_d;
         op_prev_q  <= op_prev_d;
      end
   end

`ifdef CFG_STATIC_READBACK_EN
   // readback snapshot, capture and compare result
   always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         snap_q <= '0;
         cap_q  <= '0;
         mism_q <= 1'b0;
      end else begin
         snap_q <= snap_d;
         cap_q  <= cap_d;
         mism_q <= mism_d;
      end
   end
`endif

   assign sw.fw_read_data32   = rd_q;
   assign sw.fw_read_status32 = st_q;
   assign scan_sclk           = sclk_q;
   assign scan_sdata          = sdata_q;
   assign scan_sload          = sload_q;

endmodule
